// File: rtl/signed_digit_recompose.sv
// Rebuilds a residue mod Q from NUM_DIGITS signed gadget digits (MSB first)
// by Horner evaluation: BASE_LOG modular doublings then one modular add per digit.
module signed_digit_recompose #(
    parameter int unsigned                  DATA_SIZE_ARB = 27,
    parameter logic [DATA_SIZE_ARB-1:0]     Q             = 27'h7FFF801,
    parameter int unsigned                  BASE_LOG      = 7,
    parameter int unsigned                  NUM_DIGITS    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_SIZE_ARB-1:0] digit_in,
    input  logic                     digit_valid,
    output logic                     digit_ready,
    output logic [DATA_SIZE_ARB-1:0] value_out,
    output logic                     value_valid,
    input  logic                     value_ready,
    output logic                     busy
);

    localparam int unsigned W  = DATA_SIZE_ARB;
    localparam int unsigned SW = $clog2(BASE_LOG + 1);
    localparam int unsigned DW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SHIFT,
        S_ADD,
        S_OUT
    } state_t;

    state_t          state;
    logic [W-1:0]    acc;
    logic [W-1:0]    dreg;
    logic [SW-1:0]   shift_cnt;
    logic [DW-1:0]   digit_cnt;

    logic [W:0]      dbl;
    logic [W:0]      sum;
    logic [W:0]      q_ext;
    logic [W-1:0]    acc_dbl;
    logic [W-1:0]    acc_add;

    // Both operands are already < Q, so a single conditional subtract keeps results in [0,Q).
    always_comb begin
        q_ext   = {1'b0, Q};
        dbl     = {acc, 1'b0};
        sum     = {1'b0, acc} + {1'b0, dreg};
        acc_dbl = (dbl >= q_ext) ? W'(dbl - q_ext) : W'(dbl);
        acc_add = (sum >= q_ext) ? W'(sum - q_ext) : W'(sum);
    end

    assign digit_ready = (state == S_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT;
            acc         <= '0;
            dreg        <= '0;
            shift_cnt   <= '0;
            digit_cnt   <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (digit_valid) begin
                        dreg      <= digit_in;
                        busy      <= 1'b1;
                        shift_cnt <= '0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc       <= acc_dbl;
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == SW'(BASE_LOG - 1)) begin
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    acc       <= acc_add;
                    digit_cnt <= digit_cnt + 1'b1;
                    if (digit_cnt == DW'(NUM_DIGITS - 1)) begin
                        value_out   <= acc_add;
                        value_valid <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_OUT: begin
                    if (value_ready) begin
                        value_valid <= 1'b0;
                        acc         <= '0;
                        digit_cnt   <= '0;
                        busy        <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_digit_recompose.sv
// Table-driven and randomized checks of signed_digit_recompose against a
// plain modular-arithmetic reference (Horner in 64-bit integers).
module tb_signed_digit_recompose;

    localparam int unsigned W    = 27;
    localparam logic [W-1:0] Q   = 27'h7FFF801;
    localparam int unsigned ND   = 4;
    localparam int unsigned LAT  = 36;

    typedef logic [ND-1:0][W-1:0] frame_t;   // [k] = k-th digit sent (MSB first)

    typedef struct {
        frame_t       d;
        logic [W-1:0] exp;
        int           stall;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] digit_in;
    logic         digit_valid;
    logic         digit_ready;
    logic [W-1:0] value_out;
    logic         value_valid;
    logic         value_ready;
    logic         busy;

    int vectors = 0;
    int errors  = 0;

    signed_digit_recompose #(
        .DATA_SIZE_ARB(W),
        .Q            (Q),
        .BASE_LOG     (7),
        .NUM_DIGITS   (ND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_in   (digit_in),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready),
        .value_out  (value_out),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_val(input frame_t d);
        longint unsigned v = 0;
        for (int k = 0; k < ND; k++) v = (v * 128 + longint'(d[k])) % longint'(Q);
        return W'(v);
    endfunction

    function automatic logic [W-1:0] enc(input int sd);
        return (sd < 0) ? W'(longint'(Q) + sd) : W'(sd);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame, waits for the result, optionally stalls value_ready, completes handshake.
    task automatic run_frame(input frame_t d, input int maxgap, input int stall,
                             output logic [W-1:0] v, output int lat);
        int t;
        int n;
        n = 0;
        value_ready = (stall == 0);
        for (int k = 0; k < ND; k++) begin
            if (maxgap > 0) begin
                digit_valid = 1'b0;
                repeat ($urandom_range(0, maxgap)) begin tick(); n++; end
            end
            digit_in    = d[k];
            digit_valid = 1'b1;
            t = 0;
            while (!digit_ready && t < 100) begin tick(); n++; t++; end
            if (t == 100) chk("digit_accept_timeout", 64'd1, 64'd0);
            tick();
            n = (k == 0) ? 1 : n + 1;
            if (k == 0) chk("busy_after_accept", 64'(busy), 64'd1);
        end
        digit_valid = 1'b0;
        t = 0;
        while (!value_valid && t < 200) begin tick(); n++; t++; end
        if (t == 200) chk("value_valid_timeout", 64'd1, 64'd0);
        v   = value_out;
        lat = n;
        if (stall > 0) begin
            digit_valid = 1'b1;
            digit_in    = 27'd99;
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("stall_valid", 64'(value_valid), 64'd1);
                chk("stall_value", 64'(value_out), 64'(v));
                chk("stall_ready", 64'(digit_ready), 64'd0);
            end
            value_ready = 1'b1;
        end
        tick();
        digit_valid = 1'b0;
        chk("valid_drop", 64'(value_valid), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t         tbl[$];
        vec_t         e;
        logic [W-1:0] v;
        int           lat;
        frame_t       f;

        rst = 1'b1; digit_in = '0; digit_valid = 1'b0; value_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digit_ready", 64'(digit_ready), 64'd1);
        chk("rst_value_valid", 64'(value_valid), 64'd0);
        chk("rst_value_out",   64'(value_out),   64'd0);
        chk("rst_busy",        64'(busy),        64'd0);
        rst = 1'b0;
        tick();

        e.name = "d0005";   e.d = {W'(5), W'(0), W'(0), W'(0)};         e.exp = 27'd5;        e.stall = 0;  tbl.push_back(e);
        e.name = "neg_wrap"; e.d = {Q - 27'd1, W'(1), W'(0), W'(0)};    e.exp = 27'h7F;       e.stall = 0;  tbl.push_back(e);
        e.name = "all_m64"; e.d = {Q - 27'd64, Q - 27'd64, Q - 27'd64, Q - 27'd64};
                            e.exp = 27'h7EFCFC2; e.stall = 0; tbl.push_back(e);
        e.name = "stall";   e.d = {enc(-3), enc(17), enc(-64), enc(63)}; e.exp = ref_val(e.d); e.stall = 10; tbl.push_back(e);
        e.name = "after_stall"; e.d = {enc(1), enc(2), enc(3), enc(4)}; e.exp = ref_val(e.d); e.stall = 0; tbl.push_back(e);

        foreach (tbl[i]) begin
            run_frame(tbl[i].d, 0, tbl[i].stall, v, lat);
            chk({tbl[i].name, "_value"}, 64'(v), 64'(tbl[i].exp));
            if (i == 0) chk("latency_first_accept_to_valid", 64'(lat), 64'(LAT));
        end

        // Reset after two digits: outputs return to reset values at once.
        for (int k = 0; k < 2; k++) begin
            digit_in = 27'd7; digit_valid = 1'b1;
            while (!digit_ready) tick();
            tick();
        end
        digit_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("midrst_digit_ready", 64'(digit_ready), 64'd1);
        chk("midrst_value_valid", 64'(value_valid), 64'd0);
        chk("midrst_value_out",   64'(value_out),   64'd0);
        chk("midrst_busy",        64'(busy),        64'd0);
        tick();
        rst = 1'b0;
        tick();
        f = {W'(3), W'(0), W'(0), W'(0)};
        run_frame(f, 0, 0, v, lat);
        chk("after_rst_value", 64'(v), 64'd3);

        // Random signed digits with random valid gaps and occasional output stalls.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < ND; k++) f[k] = enc($urandom_range(0, 127) - 64);
            run_frame(f, 3, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, v, lat);
            chk("random_value", 64'(v), 64'(ref_val(f)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
